// File: rtl/axis_ser_pkg.sv
// Shared types and helpers for the AXI-stream word serializer.
package axis_ser_pkg;

    // IDLE holds no record; SEND is presenting beats of a held record.
    typedef enum logic {
        IDLE,
        SEND
    } ser_state_t;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_NUM_WORDS  = 8;

    // A requested length larger than the buffer is clamped to the buffer depth.
    function automatic int clamp_len(input int len, input int max);
        return (len > max) ? max : len;
    endfunction

endpackage

// File: rtl/axis_word_serializer.sv
// Accepts one wide record per load handshake and streams its words,
// lowest word first, as DATA_WIDTH beats on an AXI-stream master port.
// A new record can be accepted on the cycle its predecessor's last beat
// completes, so back-to-back records leave no idle cycle on the stream.
module axis_word_serializer
    import axis_ser_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_WORDS  = DEFAULT_NUM_WORDS,
    localparam int CNT_W     = $clog2(NUM_WORDS + 1)
) (
    input  logic                          m_axis_aclk,
    input  logic                          m_axis_areset,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0]              in_len,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic                          busy,
    output logic [31:0]                   beats_sent
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    ser_state_t             stateQ, stateD;
    logic [DATA_WIDTH-1:0]  wordsQ [NUM_WORDS];
    logic [DATA_WIDTH-1:0]  wordsD [NUM_WORDS];
    logic [CNT_W-1:0]       idxQ, idxD;
    logic [CNT_W-1:0]       remQ, remD;
    logic [DATA_WIDTH-1:0]  tdataQ, tdataD;
    logic                   tvalidQ, tvalidD;
    logic                   tlastQ, tlastD;
    logic [31:0]            beatsQ, beatsD;

    logic [CNT_W-1:0]       effLen;
    logic [CNT_W-1:0]       idxNext;
    logic                   beatDone;
    logic                   lastDone;
    logic                   load;

    assign effLen   = CNT_W'(clamp_len(int'(in_len), NUM_WORDS));
    assign idxNext  = idxQ + CNT_W'(1);
    assign beatDone = tvalidQ & m_axis_tready;
    assign lastDone = beatDone & tlastQ;

    // Ready whenever idle, or combinationally on the final beat's handshake
    // so the next record loads without a bubble; held low during reset.
    assign in_ready = ~m_axis_areset &
                      ((stateQ == IDLE) | ((stateQ == SEND) & lastDone));
    assign load     = in_valid & in_ready;

    assign m_axis_tdata  = tdataQ;
    assign m_axis_tvalid = tvalidQ;
    assign m_axis_tlast  = tlastQ;
    assign busy          = (stateQ == SEND);
    assign beats_sent    = beatsQ;

    // Next-state logic: a load takes priority, then last-beat retirement,
    // then advancing to the next buffered word on an ordinary handshake.
    always_comb begin
        stateD  = stateQ;
        wordsD  = wordsQ;
        idxD    = idxQ;
        remD    = remQ;
        tdataD  = tdataQ;
        tvalidD = tvalidQ;
        tlastD  = tlastQ;
        beatsD  = beatsQ;

        if (beatDone) begin
            beatsD = beatsQ + 32'd1;
        end

        if (load && (effLen != '0)) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                wordsD[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
            stateD  = SEND;
            idxD    = '0;
            remD    = effLen;
            tdataD  = in_data[DATA_WIDTH-1:0];
            tvalidD = 1'b1;
            tlastD  = (effLen == CNT_W'(1));
        end else if (lastDone) begin
            stateD  = IDLE;
            idxD    = '0;
            remD    = '0;
            tvalidD = 1'b0;
            tlastD  = 1'b0;
        end else if (beatDone) begin
            idxD   = idxNext;
            remD   = remQ - CNT_W'(1);
            tdataD = wordsQ[idxNext[IDX_W-1:0]];
            tlastD = (remQ == CNT_W'(2));
        end
    end

    // State and output registers; reset aborts any record in flight.
    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) begin
            stateQ  <= IDLE;
            for (int k = 0; k < NUM_WORDS; k++) begin
                wordsQ[k] <= '0;
            end
            idxQ    <= '0;
            remQ    <= '0;
            tdataQ  <= '0;
            tvalidQ <= 1'b0;
            tlastQ  <= 1'b0;
            beatsQ  <= '0;
        end else begin
            stateQ  <= stateD;
            wordsQ  <= wordsD;
            idxQ    <= idxD;
            remQ    <= remD;
            tdataQ  <= tdataD;
            tvalidQ <= tvalidD;
            tlastQ  <= tlastD;
            beatsQ  <= beatsD;
        end
    end

endmodule

// File: tb/tb_axis_word_serializer.sv
// Directed bench for axis_word_serializer: each task drives one scenario
// and compares the stream against hand-computed beats.
module tb_axis_word_serializer;

    localparam int DW    = 32;
    localparam int NW    = 8;
    localparam int CW    = $clog2(NW + 1);

    logic               clk;
    logic               rst;
    logic [NW*DW-1:0]   inData;
    logic [CW-1:0]      inLen;
    logic               inValid;
    logic               inReady;
    logic [DW-1:0]      tdata;
    logic               tvalid;
    logic               tlast;
    logic               tready;
    logic               busy;
    logic [31:0]        beatsSent;

    int compCount = 0;
    int errCount  = 0;

    axis_word_serializer #(
        .DATA_WIDTH (DW),
        .NUM_WORDS  (NW)
    ) dut (
        .m_axis_aclk   (clk),
        .m_axis_areset (rst),
        .in_data       (inData),
        .in_len        (inLen),
        .in_valid      (inValid),
        .in_ready      (inReady),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tlast  (tlast),
        .m_axis_tready (tready),
        .busy          (busy),
        .beats_sent    (beatsSent)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge, where registered outputs
    // are stable and inputs for the following edge are driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Outputs idle during reset, in_ready forced low, then ready once released.
    task automatic test_reset();
        rst = 1'b1; inData = '0; inLen = '0; inValid = 1'b1; tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        compCount++; if (tvalid !== 1'b0) begin errCount++; $display("[TB] FAIL reset_tvalid: got %b want 0", tvalid); end
        compCount++; if (tdata !== 32'h0) begin errCount++; $display("[TB] FAIL reset_tdata: got %h want 0", tdata); end
        compCount++; if (tlast !== 1'b0) begin errCount++; $display("[TB] FAIL reset_tlast: got %b want 0", tlast); end
        compCount++; if (beatsSent !== 32'd0) begin errCount++; $display("[TB] FAIL reset_beats: got %0d want 0", beatsSent); end
        compCount++; if (inReady !== 1'b0) begin errCount++; $display("[TB] FAIL reset_in_ready: got %b want 0", inReady); end
        compCount++; if (busy !== 1'b0) begin errCount++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        inValid = 1'b0;
        rst = 1'b0;
        #1;
        compCount++; if (inReady !== 1'b1) begin errCount++; $display("[TB] FAIL idle_in_ready: got %b want 1", inReady); end
    endtask

    // Three-word record with tready held high.
    task automatic test_basic();
        logic [DW-1:0] expData [3] = '{32'hA0, 32'hA1, 32'hA2};
        inData = '0;
        for (int k = 0; k < 3; k++) inData[k*DW +: DW] = expData[k];
        inLen = CW'(3); inValid = 1'b1; tready = 1'b1;
        #1;
        compCount++; if (inReady !== 1'b1) begin errCount++; $display("[TB] FAIL basic_in_ready: got %b want 1", inReady); end
        step();
        inValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            compCount++; if (tvalid !== 1'b1) begin errCount++; $display("[TB] FAIL basic_tvalid[%0d]: got %b want 1", i, tvalid); end
            compCount++; if (tdata !== expData[i]) begin errCount++; $display("[TB] FAIL basic_tdata[%0d]: got %h want %h", i, tdata, expData[i]); end
            compCount++; if (tlast !== (i == 2)) begin errCount++; $display("[TB] FAIL basic_tlast[%0d]: got %b want %b", i, tlast, (i == 2)); end
            compCount++; if (busy !== 1'b1) begin errCount++; $display("[TB] FAIL basic_busy[%0d]: got %b want 1", i, busy); end
            step();
        end
        compCount++; if (tvalid !== 1'b0) begin errCount++; $display("[TB] FAIL basic_end_tvalid: got %b want 0", tvalid); end
        compCount++; if (busy !== 1'b0) begin errCount++; $display("[TB] FAIL basic_end_busy: got %b want 0", busy); end
        compCount++; if (beatsSent !== 32'd3) begin errCount++; $display("[TB] FAIL basic_beats: got %0d want 3", beatsSent); end
    endtask

    // Same record under backpressure: each word must hold while tready is low.
    task automatic test_backpressure();
        logic          readyPat [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [DW-1:0] expData  [6] = '{32'hA0, 32'hA0, 32'hA1, 32'hA1, 32'hA1, 32'hA2};
        logic          expLast  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        inData = '0;
        inData[0*DW +: DW] = 32'hA0;
        inData[1*DW +: DW] = 32'hA1;
        inData[2*DW +: DW] = 32'hA2;
        inLen = CW'(3); inValid = 1'b1; tready = 1'b0;
        step();
        inValid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tready = readyPat[i];
            compCount++; if (tvalid !== 1'b1) begin errCount++; $display("[TB] FAIL bp_tvalid[%0d]: got %b want 1", i, tvalid); end
            compCount++; if (tdata !== expData[i]) begin errCount++; $display("[TB] FAIL bp_tdata[%0d]: got %h want %h", i, tdata, expData[i]); end
            compCount++; if (tlast !== expLast[i]) begin errCount++; $display("[TB] FAIL bp_tlast[%0d]: got %b want %b", i, tlast, expLast[i]); end
            step();
        end
        tready = 1'b1;
        compCount++; if (tvalid !== 1'b0) begin errCount++; $display("[TB] FAIL bp_end_tvalid: got %b want 0", tvalid); end
        compCount++; if (beatsSent !== 32'd6) begin errCount++; $display("[TB] FAIL bp_beats: got %0d want 6", beatsSent); end
    endtask

    // Two 2-word records with in_valid held: no bubble between them, and the
    // second record's data is changed while the first is still streaming.
    task automatic test_back_to_back();
        inData = '0;
        inData[0*DW +: DW] = 32'h10;
        inData[1*DW +: DW] = 32'h11;
        inLen = CW'(2); inValid = 1'b1; tready = 1'b1;
        step();
        inData[0*DW +: DW] = 32'h20;
        inData[1*DW +: DW] = 32'h21;
        #1;
        compCount++; if (tdata !== 32'h10) begin errCount++; $display("[TB] FAIL b2b_tdata0: got %h want 10", tdata); end
        compCount++; if (tlast !== 1'b0) begin errCount++; $display("[TB] FAIL b2b_tlast0: got %b want 0", tlast); end
        compCount++; if (inReady !== 1'b0) begin errCount++; $display("[TB] FAIL b2b_in_ready0: got %b want 0", inReady); end
        step();
        compCount++; if (tdata !== 32'h11) begin errCount++; $display("[TB] FAIL b2b_tdata1: got %h want 11", tdata); end
        compCount++; if (tlast !== 1'b1) begin errCount++; $display("[TB] FAIL b2b_tlast1: got %b want 1", tlast); end
        compCount++; if (inReady !== 1'b1) begin errCount++; $display("[TB] FAIL b2b_in_ready1: got %b want 1", inReady); end
        step();
        inValid = 1'b0;
        compCount++; if (tvalid !== 1'b1) begin errCount++; $display("[TB] FAIL b2b_tvalid2: got %b want 1", tvalid); end
        compCount++; if (tdata !== 32'h20) begin errCount++; $display("[TB] FAIL b2b_tdata2: got %h want 20", tdata); end
        compCount++; if (tlast !== 1'b0) begin errCount++; $display("[TB] FAIL b2b_tlast2: got %b want 0", tlast); end
        step();
        compCount++; if (tdata !== 32'h21) begin errCount++; $display("[TB] FAIL b2b_tdata3: got %h want 21", tdata); end
        compCount++; if (tlast !== 1'b1) begin errCount++; $display("[TB] FAIL b2b_tlast3: got %b want 1", tlast); end
        step();
        compCount++; if (tvalid !== 1'b0) begin errCount++; $display("[TB] FAIL b2b_end_tvalid: got %b want 0", tvalid); end
        compCount++; if (beatsSent !== 32'd10) begin errCount++; $display("[TB] FAIL b2b_beats: got %0d want 10", beatsSent); end
    endtask

    // Zero-length record is consumed silently; an oversize length is clamped.
    task automatic test_len_bounds();
        inData = '0;
        inLen = '0; inValid = 1'b1; tready = 1'b1;
        #1;
        compCount++; if (inReady !== 1'b1) begin errCount++; $display("[TB] FAIL zero_in_ready: got %b want 1", inReady); end
        step();
        inValid = 1'b0;
        compCount++; if (tvalid !== 1'b0) begin errCount++; $display("[TB] FAIL zero_tvalid: got %b want 0", tvalid); end
        compCount++; if (busy !== 1'b0) begin errCount++; $display("[TB] FAIL zero_busy: got %b want 0", busy); end
        step();
        compCount++; if (tvalid !== 1'b0) begin errCount++; $display("[TB] FAIL zero_tvalid_late: got %b want 0", tvalid); end
        compCount++; if (beatsSent !== 32'd10) begin errCount++; $display("[TB] FAIL zero_beats: got %0d want 10", beatsSent); end
        for (int k = 0; k < NW; k++) inData[k*DW +: DW] = 32'h80 + k;
        inLen = CW'(12); inValid = 1'b1;
        step();
        inValid = 1'b0;
        for (int k = 0; k < NW; k++) begin
            compCount++; if (tvalid !== 1'b1) begin errCount++; $display("[TB] FAIL clamp_tvalid[%0d]: got %b want 1", k, tvalid); end
            compCount++; if (tdata !== 32'h80 + k) begin errCount++; $display("[TB] FAIL clamp_tdata[%0d]: got %h want %h", k, tdata, 32'h80 + k); end
            compCount++; if (tlast !== (k == NW - 1)) begin errCount++; $display("[TB] FAIL clamp_tlast[%0d]: got %b want %b", k, tlast, (k == NW - 1)); end
            step();
        end
        compCount++; if (tvalid !== 1'b0) begin errCount++; $display("[TB] FAIL clamp_end_tvalid: got %b want 0", tvalid); end
        compCount++; if (beatsSent !== 32'd18) begin errCount++; $display("[TB] FAIL clamp_beats: got %0d want 18", beatsSent); end
    endtask

    // Reset after two beats of a five-word record, then a single-word record.
    task automatic test_reset_mid_record();
        inData = '0;
        for (int k = 0; k < 5; k++) inData[k*DW +: DW] = 32'h50 + k;
        inLen = CW'(5); inValid = 1'b1; tready = 1'b1;
        step();
        inValid = 1'b0;
        compCount++; if (tdata !== 32'h50) begin errCount++; $display("[TB] FAIL mid_tdata0: got %h want 50", tdata); end
        step();
        compCount++; if (tdata !== 32'h51) begin errCount++; $display("[TB] FAIL mid_tdata1: got %h want 51", tdata); end
        step();
        compCount++; if (beatsSent !== 32'd20) begin errCount++; $display("[TB] FAIL mid_beats_pre: got %0d want 20", beatsSent); end
        rst = 1'b1;
        #1;
        compCount++; if (tvalid !== 1'b0) begin errCount++; $display("[TB] FAIL mid_rst_tvalid: got %b want 0", tvalid); end
        compCount++; if (tdata !== 32'h0) begin errCount++; $display("[TB] FAIL mid_rst_tdata: got %h want 0", tdata); end
        compCount++; if (beatsSent !== 32'd0) begin errCount++; $display("[TB] FAIL mid_rst_beats: got %0d want 0", beatsSent); end
        compCount++; if (inReady !== 1'b0) begin errCount++; $display("[TB] FAIL mid_rst_in_ready: got %b want 0", inReady); end
        step();
        step();
        rst = 1'b0;
        #1;
        compCount++; if (inReady !== 1'b1) begin errCount++; $display("[TB] FAIL post_rst_in_ready: got %b want 1", inReady); end
        compCount++; if (tvalid !== 1'b0) begin errCount++; $display("[TB] FAIL post_rst_tvalid: got %b want 0", tvalid); end
        inData = '0;
        inData[0*DW +: DW] = 32'h77;
        inLen = CW'(1); inValid = 1'b1;
        step();
        inValid = 1'b0;
        compCount++; if (tvalid !== 1'b1) begin errCount++; $display("[TB] FAIL single_tvalid: got %b want 1", tvalid); end
        compCount++; if (tdata !== 32'h77) begin errCount++; $display("[TB] FAIL single_tdata: got %h want 77", tdata); end
        compCount++; if (tlast !== 1'b1) begin errCount++; $display("[TB] FAIL single_tlast: got %b want 1", tlast); end
        step();
        compCount++; if (tvalid !== 1'b0) begin errCount++; $display("[TB] FAIL single_end_tvalid: got %b want 0", tvalid); end
        compCount++; if (beatsSent !== 32'd1) begin errCount++; $display("[TB] FAIL single_beats: got %0d want 1", beatsSent); end
    endtask

    // Run every scenario in order, then report totals.
    initial begin
        $display("[TB] starting axis_word_serializer bench");
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_len_bounds();
        test_reset_mid_record();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
        $finish;
    end

endmodule

// File: doc/axis_word_serializer.md
Name: axis_word_serializer

Overview:
- AXI-stream transmitter that accepts one wide record (up to NUM_WORDS words) per load handshake and emits it as consecutive DATA_WIDTH beats on an m_axis master port.
- Sits upstream of the sketch datapath's axis_data_fifo slave port. It converts the sorted-CAM/sketch result records into the 32-bit stream the FIFO buffers.
- Back-to-back records are sent with no idle bubble between them.

Parameters:
- DATA_WIDTH, 32, width of one stream beat and of one record word.
- NUM_WORDS, 8, maximum words per record; must be 2..256.
- CNT_W, $clog2(NUM_WORDS+1), localparam, width of length and remaining-count fields.

Ports:
- m_axis_aclk  in  1  the single clock.
- m_axis_areset  in  1  asynchronous, active-high reset.
- in_data  in  NUM_WORDS*DATA_WIDTH  record; word k is bits [k*DATA_WIDTH +: DATA_WIDTH], sent lowest k first.
- in_len  in  CNT_W  number of valid words in in_data.
- in_valid  in  1  record offered.
- in_ready  out  1  record accepted when in_valid & in_ready.
- m_axis_tdata  out  DATA_WIDTH  beat data.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tlast  out  1  final beat of the current record.
- m_axis_tready  in  1  downstream ready.
- busy  out  1  state == SEND.
- beats_sent  out  32  count of completed beats; wraps at 2^32.

Behaviour:
- Reset, asynchronous and active-high: state=IDLE, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, beats_sent=0, remaining=0, word buffer cleared. in_ready is forced to 0 while m_axis_areset is high.
- States:
  - IDLE: no record held.
  - SEND: record held; beats are being emitted.
- Length handling:
  - eff_len = min(in_len, NUM_WORDS), so in_len > NUM_WORDS is clamped.
  - in_len == 0 is accepted and dropped: state stays IDLE and no beat is produced.
- in_ready = (state==IDLE) | (state==SEND & m_axis_tlast & m_axis_tvalid & m_axis_tready). This is a combinational path from tready to in_ready by design; it provides the no-bubble reload.
- Load: on in_valid & in_ready with eff_len > 0:
  - Register in_data into the word buffer, set remaining = eff_len and idx = 0.
  - Enter or remain in SEND.
  - On the next cycle: m_axis_tvalid=1, m_axis_tdata=word 0, m_axis_tlast=(eff_len==1).
  - Latency from load handshake to first tvalid is 1 cycle.
- Beat handshake: a beat completes on m_axis_tvalid & m_axis_tready.
  - On completion: idx++, remaining--, beats_sent++.
  - m_axis_tdata, m_axis_tvalid and m_axis_tlast are registered outputs. Next cycle they present word idx+1, with tlast = (remaining==2 before decrement).
  - While tvalid & ~tready, tdata and tlast hold stable. tvalid never deasserts without a handshake.
- Last beat: on handshake with tlast=1, one of two things happens:
  - A simultaneous load is accepted: the new record's word 0 appears the next cycle, giving zero bubble.
  - No load is accepted: state→IDLE and tvalid=0 the next cycle.
- A load in the same cycle as the last-beat handshake with in_len==0 drops that record and goes to IDLE.
- in_data and in_len are sampled only at load; later changes are ignored.
- Reset asserted mid-record aborts the record immediately: no further beats, and beats_sent clears.
- Widths: idx and remaining are CNT_W bits and never underflow; remaining==0 only in IDLE.

Decomposition:
- Package axis_ser_pkg holds:
  - typedef enum logic {IDLE, SEND} ser_state_t;
  - localparam DEFAULT_DATA_WIDTH=32, DEFAULT_NUM_WORDS=8;
  - a function clamp_len(len, max) returning the CNT_W-bit effective length.
- Single module; no sub-module is needed. The word-select mux is inline, indexed by idx.

Test Plan:
- Load in_len=3 with words 0xA0,0xA1,0xA2 and tready held 1 → tvalid high for exactly 3 cycles starting 1 cycle after load; tdata A0,A1,A2; tlast only on A2; beats_sent=3.
- Same 3-word record with tready toggling 0,1,0,0,1,1 → each word held stable while tready=0; order A0,A1,A2 preserved; no duplicate or lost beat.
- Two 2-word records (0x10,0x11 then 0x20,0x21) with in_valid held and tready=1 → 4 consecutive valid cycles 10,11,20,21; in_ready pulses on the 0x11 beat; tlast on 11 and 21.
- in_len=0 → in_ready=1, record consumed, tvalid stays 0, beats_sent unchanged. Then in_len=12 with NUM_WORDS=8 → exactly 8 beats, tlast on the 8th.
- Assert m_axis_areset after the 2nd beat of a 5-word record → tvalid=0, tdata=0 and beats_sent=0 immediately. After release, in_ready=1 and a new 1-word load emits a single beat with tlast=1.
